// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, 32x32 register file (x0 = 0), bypassed read ports.
// Latency: bus captured at edge N, visible on wb_* during N..N+1, register file written at edge N+1.
// Backpressure: none upstream; a MEM stall, flush or exception turns the capture into a bubble.

package wb_pkg;
  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    ALUopR      = 3'd1,
    ALUopI      = 3'd2,
    LW          = 3'd3,
    SW          = 3'd4,
    DRAIN_CACHE = 3'd5
  } opcode_t;

  typedef struct packed {
    logic [31:0]     instruction;
    opcode_t         opcode;
    logic [4:0]      rd;
    logic [XLEN-1:0] wb_value;
  } mem_wb_bus_t;
endpackage

module wb_stage
  import wb_pkg::*;
#(
  parameter int REG_COUNT = 32,
  parameter int XLEN      = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  mem_wb_bus_t                  mem_wb_bus_in,
  input  logic                         mem_stall_in,
  input  logic                         flush,
  input  logic [2:0]                   excpt_in,
  input  logic [$clog2(REG_COUNT)-1:0] rs1_addr,
  input  logic [$clog2(REG_COUNT)-1:0] rs2_addr,
  output logic [XLEN-1:0]              rs1_data,
  output logic [XLEN-1:0]              rs2_data,
  output logic                         wb_valid,
  output logic [$clog2(REG_COUNT)-1:0] wb_rd,
  output logic [XLEN-1:0]              wb_value,
  output logic [31:0]                  retired_count,
  output logic                         excpt_valid,
  output logic [2:0]                   excpt_code
);

  localparam int AW = $clog2(REG_COUNT);

  logic [XLEN-1:0] rf [REG_COUNT];

  // Registered MEM/WB slot; data fields hold their previous values across bubbles.
  logic            live_q;
  logic [31:0]     instr_q;
  opcode_t         opcode_q;
  logic [AW-1:0]   rd_q;
  logic [XLEN-1:0] value_q;

  logic slot_live;
  logic writes_rf;
  logic wr_en;
  logic retire_en;

  // A slot is a real instruction only when nothing stalls, squashes or traps it.
  assign slot_live = ~mem_stall_in & ~flush & ~excpt_valid & (excpt_in == 3'd0);

  // Only ALU results and loads produce a register value; stores, cache drains and
  // unknown opcodes retire silently. Destination x0 never commits.
  always_comb begin
    writes_rf = 1'b0;
    case (opcode_q)
      ALUopR, ALUopI, LW: writes_rf = 1'b1;
      default:            writes_rf = 1'b0;
    endcase
  end

  assign wr_en     = live_q & writes_rf & (rd_q != '0);
  assign retire_en = live_q;

  assign wb_valid = wr_en;
  assign wb_rd    = rd_q;
  assign wb_value = value_q;

  // Capture the MEM bus into the pipeline register, or insert a bubble.
  always_ff @(posedge clock) begin
    if (reset) begin
      live_q   <= 1'b0;
      instr_q  <= '0;
      opcode_q <= OP_NOP;
      rd_q     <= '0;
      value_q  <= '0;
    end else begin
      live_q <= slot_live;
      if (slot_live) begin
        instr_q  <= mem_wb_bus_in.instruction;
        opcode_q <= mem_wb_bus_in.opcode;
        rd_q     <= mem_wb_bus_in.rd[AW-1:0];
        value_q  <= mem_wb_bus_in.wb_value;
      end
    end
  end

  // Commit the registered instruction into the register file.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) rf[i] <= '0;
    end else if (wr_en) begin
      rf[rd_q] <= value_q;
    end
  end

  // Count retirements; the counter wraps naturally at 2^32.
  always_ff @(posedge clock) begin
    if (reset) retired_count <= '0;
    else if (retire_en) retired_count <= retired_count + 32'd1;
  end

  // Latch the first nonzero exception code; sticky until reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      excpt_valid <= 1'b0;
      excpt_code  <= '0;
    end else if (!excpt_valid && excpt_in != 3'd0) begin
      excpt_valid <= 1'b1;
      excpt_code  <= excpt_in;
    end
  end

  // Read ports: x0 is zero, the committing write is bypassed, otherwise the file.
  always_comb begin
    rs1_data = rf[rs1_addr];
    if (rs1_addr == '0) rs1_data = '0;
    else if (wb_valid && wb_rd == rs1_addr) rs1_data = wb_value;

    rs2_data = rf[rs2_addr];
    if (rs2_addr == '0) rs2_data = '0;
    else if (wb_valid && wb_rd == rs2_addr) rs2_data = wb_value;
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: reset, bypass, x0, stall, non-writing ops, exceptions, back-to-back.
// Inputs change 1 time unit after the rising edge; outputs are checked in the same window.
// Each scenario task starts from a fresh reset and carries its own expected values.

module tb_wb_stage;
  import wb_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  mem_wb_bus_t bus;
  logic        mem_stall_in;
  logic        flush;
  logic [2:0]  excpt_in;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_value;
  logic [31:0] retired_count;
  logic        excpt_valid;
  logic [2:0]  excpt_code;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clock = ~clock;

  wb_stage dut (
    .clock         (clock),
    .reset         (reset),
    .mem_wb_bus_in (bus),
    .mem_stall_in  (mem_stall_in),
    .flush         (flush),
    .excpt_in      (excpt_in),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_value      (wb_value),
    .retired_count (retired_count),
    .excpt_valid   (excpt_valid),
    .excpt_code    (excpt_code)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input opcode_t op, input logic [4:0] rd, input logic [31:0] val);
    bus = '{instruction: 32'h1234_0000 | {27'd0, rd}, opcode: op, rd: rd, wb_value: val};
    mem_stall_in = 1'b0;
  endtask

  task automatic idle();
    mem_stall_in = 1'b1;
    flush        = 1'b0;
    excpt_in     = 3'd0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    drive(ALUopR, 5'd5, 32'h0000_0099);
    step();
    do_reset();
    rs1_addr = 5'd5;
    total_cnt++; if (wb_valid !== 1'b0) $display("FAIL reset_wb_valid got=%0b exp=0", wb_valid); else pass_cnt++;
    total_cnt++; if (wb_rd !== 5'd0) $display("FAIL reset_wb_rd got=%0d exp=0", wb_rd); else pass_cnt++;
    total_cnt++; if (wb_value !== 32'd0) $display("FAIL reset_wb_value got=%h exp=0", wb_value); else pass_cnt++;
    total_cnt++; if (retired_count !== 32'd0) $display("FAIL reset_retired got=%0d exp=0", retired_count); else pass_cnt++;
    total_cnt++; if ({excpt_valid, excpt_code} !== 4'd0) $display("FAIL reset_excpt got=%b exp=0000", {excpt_valid, excpt_code}); else pass_cnt++;
    #1;
    total_cnt++; if (rs1_data !== 32'd0) $display("FAIL reset_rf5 got=%h exp=0", rs1_data); else pass_cnt++;
  endtask

  task automatic test_alu_bypass();
    do_reset();
    rs1_addr = 5'd5;
    drive(ALUopR, 5'd5, 32'h0000_002A);
    step();
    total_cnt++; if (wb_valid !== 1'b1) $display("FAIL alu_wb_valid got=%0b exp=1", wb_valid); else pass_cnt++;
    total_cnt++; if (wb_rd !== 5'd5) $display("FAIL alu_wb_rd got=%0d exp=5", wb_rd); else pass_cnt++;
    total_cnt++; if (wb_value !== 32'h2A) $display("FAIL alu_wb_value got=%h exp=2a", wb_value); else pass_cnt++;
    total_cnt++; if (rs1_data !== 32'h2A) $display("FAIL alu_bypass got=%h exp=2a", rs1_data); else pass_cnt++;
    idle();
    step();
    total_cnt++; if (wb_valid !== 1'b0) $display("FAIL alu_bubble got=%0b exp=0", wb_valid); else pass_cnt++;
    total_cnt++; if (rs1_data !== 32'h2A) $display("FAIL alu_rf5 got=%h exp=2a", rs1_data); else pass_cnt++;
    total_cnt++; if (retired_count !== 32'd1) $display("FAIL alu_retired got=%0d exp=1", retired_count); else pass_cnt++;
  endtask

  task automatic test_x0();
    do_reset();
    rs1_addr = 5'd0;
    drive(LW, 5'd0, 32'hDEAD_BEEF);
    step();
    total_cnt++; if (wb_valid !== 1'b0) $display("FAIL x0_wb_valid got=%0b exp=0", wb_valid); else pass_cnt++;
    total_cnt++; if (rs1_data !== 32'd0) $display("FAIL x0_read_cap got=%h exp=0", rs1_data); else pass_cnt++;
    idle();
    step();
    total_cnt++; if (rs1_data !== 32'd0) $display("FAIL x0_read_commit got=%h exp=0", rs1_data); else pass_cnt++;
    total_cnt++; if (retired_count !== 32'd1) $display("FAIL x0_retired got=%0d exp=1", retired_count); else pass_cnt++;
  endtask

  task automatic test_stall();
    do_reset();
    rs1_addr = 5'd3;
    drive(ALUopI, 5'd3, 32'd7);
    mem_stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++; if (wb_valid !== 1'b0) $display("FAIL stall_bubble%0d got=%0b exp=0", i, wb_valid); else pass_cnt++;
    end
    mem_stall_in = 1'b0;
    step();
    total_cnt++; if (wb_valid !== 1'b1) $display("FAIL stall_release got=%0b exp=1", wb_valid); else pass_cnt++;
    idle();
    step();
    step();
    total_cnt++; if (rs1_data !== 32'd7) $display("FAIL stall_rf3 got=%h exp=7", rs1_data); else pass_cnt++;
    total_cnt++; if (retired_count !== 32'd1) $display("FAIL stall_retired got=%0d exp=1", retired_count); else pass_cnt++;
  endtask

  task automatic test_flush();
    do_reset();
    rs1_addr = 5'd7;
    drive(ALUopR, 5'd7, 32'h77);
    flush = 1'b1;
    step();
    total_cnt++; if (wb_valid !== 1'b0) $display("FAIL flush_wb_valid got=%0b exp=0", wb_valid); else pass_cnt++;
    mem_stall_in = 1'b1;
    step();
    total_cnt++; if (wb_valid !== 1'b0) $display("FAIL flush_stall_wb_valid got=%0b exp=0", wb_valid); else pass_cnt++;
    idle();
    step();
    total_cnt++; if (retired_count !== 32'd0) $display("FAIL flush_retired got=%0d exp=0", retired_count); else pass_cnt++;
    total_cnt++; if (rs1_data !== 32'd0) $display("FAIL flush_rf7 got=%h exp=0", rs1_data); else pass_cnt++;
  endtask

  task automatic test_no_write();
    do_reset();
    rs1_addr = 5'd9;
    drive(SW, 5'd9, 32'h55);
    step();
    total_cnt++; if (wb_valid !== 1'b0) $display("FAIL sw_wb_valid got=%0b exp=0", wb_valid); else pass_cnt++;
    drive(DRAIN_CACHE, 5'd9, 32'h66);
    step();
    total_cnt++; if (wb_valid !== 1'b0) $display("FAIL drain_wb_valid got=%0b exp=0", wb_valid); else pass_cnt++;
    idle();
    step();
    total_cnt++; if (rs1_data !== 32'd0) $display("FAIL nowrite_rf9 got=%h exp=0", rs1_data); else pass_cnt++;
    total_cnt++; if (retired_count !== 32'd2) $display("FAIL nowrite_retired got=%0d exp=2", retired_count); else pass_cnt++;
  endtask

  task automatic test_exception();
    do_reset();
    rs1_addr = 5'd4;
    drive(ALUopR, 5'd4, 32'd1);
    step();
    drive(ALUopR, 5'd4, 32'd2);
    excpt_in = 3'd3;
    step();
    total_cnt++; if (excpt_valid !== 1'b1) $display("FAIL exc_valid got=%0b exp=1", excpt_valid); else pass_cnt++;
    total_cnt++; if (excpt_code !== 3'd3) $display("FAIL exc_code got=%0d exp=3", excpt_code); else pass_cnt++;
    total_cnt++; if (wb_valid !== 1'b0) $display("FAIL exc_squash got=%0b exp=0", wb_valid); else pass_cnt++;
    total_cnt++; if (rs1_data !== 32'd1) $display("FAIL exc_rf4_first got=%h exp=1", rs1_data); else pass_cnt++;
    drive(ALUopR, 5'd4, 32'd9);
    excpt_in = 3'd5;
    step();
    total_cnt++; if (excpt_code !== 3'd3) $display("FAIL exc_sticky got=%0d exp=3", excpt_code); else pass_cnt++;
    drive(ALUopR, 5'd4, 32'd8);
    excpt_in = 3'd0;
    step();
    total_cnt++; if (wb_valid !== 1'b0) $display("FAIL exc_later_bubble got=%0b exp=0", wb_valid); else pass_cnt++;
    idle();
    step();
    total_cnt++; if (rs1_data !== 32'd1) $display("FAIL exc_rf4_final got=%h exp=1", rs1_data); else pass_cnt++;
    total_cnt++; if (retired_count !== 32'd1) $display("FAIL exc_retired got=%0d exp=1", retired_count); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    rs1_addr = 5'd6;
    rs2_addr = 5'd6;
    drive(ALUopR, 5'd6, 32'h10);
    step();
    total_cnt++; if (rs1_data !== 32'h10) $display("FAIL b2b_rs1_first got=%h exp=10", rs1_data); else pass_cnt++;
    total_cnt++; if (rs2_data !== 32'h10) $display("FAIL b2b_rs2_first got=%h exp=10", rs2_data); else pass_cnt++;
    drive(ALUopR, 5'd6, 32'h20);
    step();
    total_cnt++; if (rs1_data !== 32'h20) $display("FAIL b2b_rs1_second got=%h exp=20", rs1_data); else pass_cnt++;
    total_cnt++; if (rs2_data !== 32'h20) $display("FAIL b2b_rs2_second got=%h exp=20", rs2_data); else pass_cnt++;
    idle();
    step();
    total_cnt++; if (rs1_data !== 32'h20) $display("FAIL b2b_rf6 got=%h exp=20", rs1_data); else pass_cnt++;
    total_cnt++; if (retired_count !== 32'd2) $display("FAIL b2b_retired got=%0d exp=2", retired_count); else pass_cnt++;
    drive(ALUopR, 5'd6, 32'h30);
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle();
    total_cnt++; if (wb_valid !== 1'b0) $display("FAIL midreset_wb_valid got=%0b exp=0", wb_valid); else pass_cnt++;
    total_cnt++; if (rs1_data !== 32'd0) $display("FAIL midreset_rf6 got=%h exp=0", rs1_data); else pass_cnt++;
    total_cnt++; if (retired_count !== 32'd0) $display("FAIL midreset_retired got=%0d exp=0", retired_count); else pass_cnt++;
  endtask

  initial begin
    reset    = 1'b1;
    bus      = '{instruction: 32'd0, opcode: OP_NOP, rd: 5'd0, wb_value: 32'd0};
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;
    idle();
    step();
    test_reset();
    test_alu_bypass();
    test_x0();
    test_stall();
    test_flush();
    test_no_write();
    test_exception();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Write-back stage directly downstream of MEM. It consumes `mem_wb_bus_t`, registers it into a MEM/WB pipeline register with bubble insertion on MEM stall or flush, and commits results into a 32x32 register file with x0 hardwired to zero. It provides bypassed read ports to decode and a forwarding tap to EX. It also counts retired instructions and latches the first exception seen.

Parameters:
REG_COUNT, 32, number of architectural registers (index width = $clog2(REG_COUNT) = 5)
XLEN, 32, data width of registers and wb_value

Ports:
clock  input  1  stage clock, all state updates on posedge
reset  input  1  synchronous, active-high; clears all state on a clock edge where it is high
mem_wb_bus_in  input  mem_wb_bus_t  instruction, opcode, rd, wb_value from MEM
mem_stall_in  input  1  MEM stall; the bus is not a completed instruction this cycle
flush  input  1  squash the instruction being captured this cycle
excpt_in  input  3  exception code, 0 = none
rs1_addr  input  5  decode read address 1
rs2_addr  input  5  decode read address 2
rs1_data  output  XLEN  bypassed read data 1
rs2_data  output  XLEN  bypassed read data 2
wb_valid  output  1  registered stage holds a committing register write
wb_rd  output  5  destination of the registered instruction
wb_value  output  XLEN  value of the registered instruction (EX forwarding tap)
retired_count  output  32  instructions retired since reset
excpt_valid  output  1  sticky: an exception has been latched
excpt_code  output  3  first nonzero excpt_in seen since reset

Behaviour:
- Reset (sync, high on an edge):
  - all REG_COUNT registers = 0
  - pipeline register cleared: valid=0, rd=0, value=0, opcode=0
  - wb_valid=0, wb_rd=0, wb_value=0
  - retired_count=0, excpt_valid=0, excpt_code=0
  - reset wins over every other input on the same edge.
- Capture, every posedge when not in reset:
  - slot_live = ~mem_stall_in & ~flush & ~excpt_valid & (excpt_in==0).
  - If slot_live:
    - latch instruction, opcode, rd, wb_value.
    - retire_en = 1.
    - wr_en = opcode in {ALUopR, ALUopI, LW} and rd != 0.
  - Otherwise latch a bubble: wr_en=0, retire_en=0; data fields hold their old values.
  - Opcodes SW and DRAIN_CACHE retire (retire_en=1) but never write.
  - Unknown opcodes retire without writing.
- Commit, one edge after capture:
  - if registered wr_en, rf[wb_rd] <= wb_value.
  - if registered retire_en, retired_count += 1, wrapping 0xFFFFFFFF -> 0.
- Latency: bus sampled at edge N; wb_valid/wb_rd/wb_value visible during cycle N..N+1; register file updated at edge N+1.
- Outputs: wb_valid = registered wr_en; wb_rd/wb_value = registered fields.
- Read ports (combinational):
  - rsX_data = 0 if rsX_addr == 0.
  - else wb_value if wb_valid & wb_rd == rsX_addr (write-through bypass).
  - else rf[rsX_addr].
  - Both ports are independent and may address the same register.
- Exceptions:
  - On the first edge with excpt_in != 0 and excpt_valid == 0: excpt_code <= excpt_in, excpt_valid <= 1.
  - excpt_valid and excpt_code are sticky until reset; later codes are ignored.
  - While excpt_valid=1, every capture is a bubble: no writes, no retires. The instruction already in the registered stage still commits.
- Simultaneous events:
  - flush & mem_stall_in -> one bubble.
  - excpt_in != 0 with a valid bus -> instruction squashed, code latched.
  - Capture of a new instruction and commit of the previous one occur on the same edge with no conflict.
  - Back-to-back writes to the same rd: the later one wins in the register file, and the bypass shows the newest value.
- x0: never written. Reads of x0 return 0 even if a bus with rd=0 arrives.

Test Plan:
- Reset then ALUopR rd=5 value=0x0000_002A, no stall -> next cycle wb_valid=1, wb_rd=5, rs1_addr=5 gives 0x2A via bypass; after the following edge rf[5]=0x2A, retired_count=1.
- LW rd=0 value=0xDEAD_BEEF -> wb_valid=0, rs1_addr=0 returns 0, retired_count increments to 1.
- ALUopI rd=3 value=7 held with mem_stall_in=1 for 3 cycles, then released -> exactly one write rf[3]=7, retired_count=1 (not 4).
- SW then DRAIN_CACHE, rd=9 -> rf[9] unchanged (0), retired_count=2, wb_valid stays 0.
- ALUopR rd=4 value=1, then excpt_in=3 on the next instruction (ALUopR rd=4 value=2), then excpt_in=5 -> rf[4]=1, excpt_valid=1, excpt_code=3, all later instructions are bubbles.
- Back-to-back ALUopR rd=6 values 0x10 then 0x20, both rs1_addr and rs2_addr=6 -> bypass shows 0x10 then 0x20; final rf[6]=0x20. Asserting reset mid-sequence clears rf[6] to 0 and retired_count to 0 on that edge.
